// File: rtl/pipelined_read_mux.sv
// Register-file read-port selector: picks one of NUM_INPUTS packed words and registers it.
// Define MUX_BYPASS_EN to forward a same-cycle write-back and count forwarded reads.
module pipelined_read_mux #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_INPUTS  = 32,
  parameter int NBITS       = $clog2(NUM_INPUTS),
  parameter bit ZERO_REG    = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_INPUTS*WORD_LENGTH-1:0] Data_In,
  input  logic [NBITS-1:0]                  Selector,
  input  logic                              In_Valid,
  input  logic                              Stall,
  input  logic                              Wr_En,
  input  logic [NBITS-1:0]                  Wr_Addr,
  input  logic [WORD_LENGTH-1:0]            Wr_Data,
  output logic [WORD_LENGTH-1:0]            Mux_Output,
  output logic                              Out_Valid,
  output logic                              Sel_Error,
  output logic [15:0]                       Fwd_Count
);

  logic [WORD_LENGTH-1:0] words [NUM_INPUTS];
  logic [WORD_LENGTH-1:0] selWord;
  logic                   inRange;
  logic                   isZeroReg;

  logic [WORD_LENGTH-1:0] muxOutQ, muxOutD;
  logic                   outValidQ, outValidD;
  logic                   selErrQ, selErrD;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : gUnpack
    assign words[g] = Data_In[g*WORD_LENGTH +: WORD_LENGTH];
  end

  // Out-of-range indices exist only for non-power-of-2 NUM_INPUTS; never let them index words.
  assign inRange   = (32'(Selector) < NUM_INPUTS);
  assign isZeroReg = ZERO_REG && (Selector == '0);
  assign selWord   = inRange ? words[Selector] : '0;

`ifdef MUX_BYPASS_EN
  logic        fwdHit;
  logic [15:0] fwdCountQ, fwdCountD;

  assign fwdHit = Wr_En && (Wr_Addr == Selector) && inRange && !isZeroReg;
`else
  logic unusedWrPort;
  assign unusedWrPort = ^{Wr_En, Wr_Addr, Wr_Data};
`endif

  always_comb begin
    muxOutD   = muxOutQ;
    outValidD = outValidQ;
    selErrD   = selErrQ;
`ifdef MUX_BYPASS_EN
    fwdCountD = fwdCountQ;
`endif
    if (!Stall) begin
      outValidD = In_Valid;
      if (In_Valid) begin
        selErrD = 1'b0;
        if (!inRange) begin
          muxOutD = '0;
          selErrD = 1'b1;
        end else if (isZeroReg) begin
          muxOutD = '0;
`ifdef MUX_BYPASS_EN
        end else if (fwdHit) begin
          muxOutD = Wr_Data;
          if (fwdCountQ != 16'hFFFF) fwdCountD = fwdCountQ + 16'd1;
`endif
        end else begin
          muxOutD = selWord;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      muxOutQ   <= '0;
      outValidQ <= 1'b0;
      selErrQ   <= 1'b0;
`ifdef MUX_BYPASS_EN
      fwdCountQ <= 16'h0000;
`endif
    end else begin
      muxOutQ   <= muxOutD;
      outValidQ <= outValidD;
      selErrQ   <= selErrD;
`ifdef MUX_BYPASS_EN
      fwdCountQ <= fwdCountD;
`endif
    end
  end

  assign Mux_Output = muxOutQ;
  assign Out_Valid  = outValidQ;
  assign Sel_Error  = selErrQ;
`ifdef MUX_BYPASS_EN
  assign Fwd_Count  = fwdCountQ;
`else
  assign Fwd_Count  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipelined_read_mux.sv
// Bench for pipelined_read_mux: a 32-input and a 20-input instance share stimulus and are
// checked every cycle against a rule-level reference model.
module tb_pipelined_read_mux;

`ifdef MUX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1023:0] dataIn;
  logic [4:0]    selector;
  logic          inValid, stall, wrEn;
  logic [4:0]    wrAddr;
  logic [31:0]   wrData;

  logic [31:0] muxOutA, muxOutB;
  logic        outValidA, outValidB, selErrA, selErrB;
  logic [15:0] fwdA, fwdB;

  logic [31:0] wordsMem [32];

  // Reference state: index 0 is the 32-input instance, index 1 the 20-input one.
  int          nIn [2] = '{32, 20};
  logic [31:0] mOut [2];
  logic        mValid [2];
  logic        mErr [2];
  logic [15:0] mFwd [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 32; k++) dataIn[k*32 +: 32] = wordsMem[k];
  end

  pipelined_read_mux #(.WORD_LENGTH(32), .NUM_INPUTS(32), .ZERO_REG(1'b1)) dutA (
    .clk(clk), .reset(reset), .Data_In(dataIn), .Selector(selector),
    .In_Valid(inValid), .Stall(stall), .Wr_En(wrEn), .Wr_Addr(wrAddr), .Wr_Data(wrData),
    .Mux_Output(muxOutA), .Out_Valid(outValidA), .Sel_Error(selErrA), .Fwd_Count(fwdA)
  );

  pipelined_read_mux #(.WORD_LENGTH(32), .NUM_INPUTS(20), .ZERO_REG(1'b1)) dutB (
    .clk(clk), .reset(reset), .Data_In(dataIn[20*32-1:0]), .Selector(selector),
    .In_Valid(inValid), .Stall(stall), .Wr_En(wrEn), .Wr_Addr(wrAddr), .Wr_Data(wrData),
    .Mux_Output(muxOutB), .Out_Valid(outValidB), .Sel_Error(selErrB), .Fwd_Count(fwdB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Apply the rules to the inputs that were present at the edge just taken.
  task automatic modelStep();
    int s;
    s = int'(selector);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        mOut[i] = 0; mValid[i] = 0; mErr[i] = 0; mFwd[i] = 0;
      end else if (!stall) begin
        mValid[i] = inValid;
        if (inValid) begin
          mErr[i] = 0;
          if (s >= nIn[i]) begin
            mOut[i] = 0;
            mErr[i] = 1;
          end else if (s == 0) begin
            mOut[i] = 0;
          end else if (BYP && wrEn && int'(wrAddr) == s) begin
            mOut[i] = wrData;
            if (mFwd[i] != 16'hFFFF) mFwd[i] = mFwd[i] + 16'd1;
          end else begin
            mOut[i] = wordsMem[s];
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stl, input logic vld,
                               input logic [4:0] sel, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
    reset = rst; stall = stl; inValid = vld; selector = sel;
    wrEn = we; wrAddr = wa; wrData = wd;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("outA",   muxOutA,           mOut[0]);
    checkOutput("validA", 32'(outValidA),    32'(mValid[0]));
    checkOutput("errA",   32'(selErrA),      32'(mErr[0]));
    checkOutput("fwdA",   32'(fwdA),         32'(mFwd[0]));
    checkOutput("outB",   muxOutB,           mOut[1]);
    checkOutput("validB", 32'(outValidB),    32'(mValid[1]));
    checkOutput("errB",   32'(selErrB),      32'(mErr[1]));
    checkOutput("fwdB",   32'(fwdB),         32'(mFwd[1]));
  endtask

  initial begin
    for (int k = 0; k < 32; k++) wordsMem[k] = 32'hA5A5_0000 + 32'(k);
    for (int i = 0; i < 2; i++) begin
      mOut[i] = 0; mValid[i] = 0; mErr[i] = 0; mFwd[i] = 0;
    end
    reset = 1'b0; stall = 1'b0; inValid = 1'b0; selector = '0;
    wrEn = 1'b0; wrAddr = '0; wrData = '0;
    #1;

    // Reset held with a live read request.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
    checkOutput("rstOut", muxOutA, 32'h0);

    // Back-to-back sweep of every index.
    for (int k = 0; k < 32; k++)
      applyStimulus(1'b1, 1'b0, 1'b1, 5'(k), 1'b0, 5'd0, 32'h0);
    checkOutput("sweepLast", muxOutA, 32'hA5A5_001F);

    // Stall freezes the accepted read.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
    checkOutput("stallHold", muxOutA, 32'hA5A5_0007);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
    checkOutput("stallRelease", muxOutA, 32'hA5A5_0009);

    // Out-of-range read on the 20-input instance, then a clearing read.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd25, 1'b0, 5'd0, 32'h0);
    checkOutput("rangeErr", 32'(selErrB), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
    checkOutput("rangeClr", 32'(selErrB), 32'h0);

    // Idle cycle drops Out_Valid but keeps data.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd12, 1'b0, 5'd0, 32'h0);

    // Write-back coinciding with a read, then aimed at the zero register.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4, 32'hDEAD_BEEF);
    checkOutput("bypassOut", muxOutA, BYP ? 32'hDEAD_BEEF : 32'hA5A5_0004);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    checkOutput("bypassZero", muxOutA, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 32'h1234_5678);

`ifdef MUX_BYPASS_EN
    // Drive the forward counter past its ceiling, then reset it mid-stream.
    for (int n = 0; n < 65537; n++)
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd6, 32'(n));
    checkOutput("fwdSat", 32'(fwdA), 32'h0000_FFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 5'd6, 32'h0);
    checkOutput("fwdReset", 32'(fwdA), 32'h0);
`endif

    // Randomised traffic, with write addresses biased toward the read index.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] s;
      logic [4:0] wa;
      s  = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 1) == 1) ? s : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wordsMem[$urandom_range(0, 31)] = $urandom;
      applyStimulus(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 1)),
                    wa, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
